mon_commit_serializer: RTL and testbench
========================================

// Module: mon_commit_serializer
// PURPOSE
//  Collects per-channel RVFI-style retirement packets (up to CHANNELS per cycle) and replays them one per
//  cycle, in program order, onto a single monitor channel. It sits between a multi-issue core's commit
//  stage and the single-channel monitor/checker. It also checks order continuity and records sticky errors.
// PARAMETERS
//  CHANNELS  2   retirement channels sampled per cycle (>=1)
//  DEPTH     16  buffer entries; power of two, DEPTH >= 2*CHANNELS
// PORTS
//  clk           in   1               clock, rising edge
//  rst           in   1               reset, asynchronous, active-high
//  in_valid      in   [CHANNELS]      channel c retires a packet this cycle
//  in_pkt        in   [CHANNELS] mon_pkt_t  retirement packet per channel
//  out_valid     out  1               out_pkt holds one retired instruction this cycle
//  out_pkt       out  mon_pkt_t       serialized packet (registered)
//  halted        out  1               a halt packet has been emitted; output is frozen
//  overflow_err  out  1               sticky: a cycle's packets did not fit and were dropped
//  order_err     out  1               sticky: emitted order != expected order
//  count         out  $clog2(DEPTH+1) occupied entries
// BEHAVIOUR
//  Reset (async, any cycle): out_valid=0, out_pkt='0, halted=0, overflow_err=0, order_err=0, count=0.
//   Also clears rd/wr pointers and exp_order=0. Contents of storage are don't-care.
//  Enqueue:
//   - Valid inputs are compacted in ascending channel index; invalid channels are skipped.
//   - n_in = popcount(in_valid) entries are written at wr_ptr..wr_ptr+n_in-1 (mod DEPTH).
//   - Acceptance is all-or-nothing. If n_in > DEPTH-count (count before this cycle's dequeue):
//     nothing is written and overflow_err<=1.
//  Dequeue:
//   - When count!=0 and !halted, the head is popped each cycle into out_pkt, with out_valid<=1.
//   - Otherwise out_valid<=0 and out_pkt holds its last value.
//  Latency: a packet enqueued in cycle N appears on out_pkt no earlier than cycle N+1.
//   There is no bypass from in_pkt to out_pkt.
//  Simultaneous enqueue and dequeue: count_next = count + n_in_accepted - pop.
//   A slot freed by this cycle's pop is not reusable until the next cycle.
//  Pointers are $clog2(DEPTH) bits wide and wrap naturally. Full and empty are distinguished by count.
//  Order check: on each pop, compare head.order to exp_order.
//   - On mismatch, order_err<=1.
//   - exp_order <= head.order + 1 in all cases, so a single gap is flagged once.
//   - Arithmetic is 64-bit and wraps.
//  Halt:
//   - Popping a packet with halt=1 emits it (out_valid=1 that cycle) and sets halted<=1.
//   - No further pops occur until reset.
//   - Enqueue continues while halted; overflow rules still apply.
//  Packets are never reordered within the block. The producer guarantees the channel order equals
//   program order.
// STRUCTURE
//  Package mon_pkg:
//   - mon_pkt_t packed struct: order[63:0], inst, halt, rs1_addr, rs2_addr, rs1_rdata, rs2_rdata,
//     rd_addr, rd_wdata, pc_rdata, pc_wdata, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata
//     (376 bits).
//   - localparam MON_PKT_W = $bits(mon_pkt_t).
//  Sub-module mon_commit_fifo: multi-write (CHANNELS compacted ports), single-read circular buffer.
//   Exposes count, wr_ok, and pop. The top level holds the halt, order-check and output registers.
// TESTING
//  1. Reset then idle 10 cycles -> out_valid=0, count=0, all flags 0.
//  2. CHANNELS=2: cycle0 in_valid=11, orders 0/1; cycle1 in_valid=01, order 2
//     -> out orders 0,1,2 on cycles 1,2,3; order_err=0.
//  3. Burst of 2 packets per cycle with no pops possible (halted) until count=16; one more valid
//     -> overflow_err=1, count stays 16, no partial write.
//  4. Orders 0,1,3,4 -> order_err sets on the pop of 3; exp_order=5 after the pop of 4;
//     no additional error.
//  5. Packet order 5 with halt=1 followed by order 6 queued -> order 5 emitted with out_valid=1,
//     halted=1, order 6 never emitted, count=1.
//  6. Assert rst asynchronously mid-burst with count=7 -> outputs zero before the next clk edge;
//     after release, order 0 is accepted without order_err.

Source files
------------

// File: rtl/mon_pkg.sv
// rtl/mon_pkg.sv - retirement packet type shared by the commit serializer blocks
// Purpose: defines the RVFI-style retirement packet carried from the commit
// stage to the single-channel monitor.
package mon_pkg;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic        halt;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } mon_pkt_t;

  localparam int MON_PKT_W = $bits(mon_pkt_t);

endpackage

// File: rtl/mon_commit_fifo.sv
// rtl/mon_commit_fifo.sv - multi-write, single-read circular buffer of retirement packets
// Purpose: accepts up to CHANNELS packets per cycle, compacted in ascending
// channel order, all-or-nothing; releases one packet per pop.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   wr_valid   per-channel write request
//   wr_data    per-channel packet
//   pop        remove the head this cycle (ignored when empty)
//   head       packet at the read pointer
//   count      occupied entries
//   wr_ok      this cycle's writes fit and are being accepted
module mon_commit_fifo
  import mon_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      wr_valid,
  input  mon_pkt_t [CHANNELS-1:0]  wr_data,
  input  logic                     pop,
  output mon_pkt_t                 head,
  output logic [CW-1:0]            count,
  output logic                     wr_ok
);

  mon_pkt_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] n_in;
  logic [CW-1:0] n_acc;
  logic [PW-1:0] waddr [CHANNELS];
  logic          do_pop;

  // Each valid channel lands at wr_ptr plus the number of valid channels
  // below it, so invalid channels leave no holes in the buffer.
  always_comb begin
    n_in = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      waddr[c] = wr_ptr + n_in[PW-1:0];
      n_in     = n_in + CW'(wr_valid[c]);
    end
  end

  // Room is judged on the occupancy before this cycle's pop, so a slot
  // being freed right now cannot be reused until the next cycle.
  assign wr_ok  = (n_in <= (CW'(DEPTH) - count));
  assign n_acc  = wr_ok ? n_in : '0;
  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_acc[PW-1:0];
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + n_acc - CW'(do_pop);
    end
  end

  // Storage contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_ok && wr_valid[c]) begin
        mem[waddr[c]] <= wr_data[c];
      end
    end
  end

endmodule

// File: rtl/mon_commit_serializer.sv
// rtl/mon_commit_serializer.sv - serializes multi-channel retirements onto one monitor channel
// Purpose: buffers up to CHANNELS retirement packets per cycle and replays
// them one per cycle in program order, checking order continuity and
// freezing the output after a halt packet.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      per-channel retirement strobe
//   in_pkt        per-channel retirement packet
//   out_valid     out_pkt holds a retired instruction this cycle
//   out_pkt       serialized packet (registered)
//   halted        a halt packet has been emitted; no further pops
//   overflow_err  sticky: a cycle's packets were dropped for lack of room
//   order_err     sticky: an emitted order broke the expected sequence
//   count         occupied buffer entries
module mon_commit_serializer
  import mon_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      in_valid,
  input  mon_pkt_t [CHANNELS-1:0]  in_pkt,
  output logic                     out_valid,
  output mon_pkt_t                 out_pkt,
  output logic                     halted,
  output logic                     overflow_err,
  output logic                     order_err,
  output logic [CW-1:0]            count
);

  mon_pkt_t    head;
  logic        wr_ok;
  logic        pop;
  logic [63:0] exp_order;

  assign pop = (count != '0) && !halted;

  mon_commit_fifo #(
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_data  (in_pkt),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .wr_ok    (wr_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pkt      <= '0;
      halted       <= 1'b0;
      overflow_err <= 1'b0;
      order_err    <= 1'b0;
      exp_order    <= '0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_pkt <= head;
        if (head.order != exp_order) begin
          order_err <= 1'b1;
        end
        // Resync to what was actually seen so a single gap is flagged once.
        exp_order <= head.order + 64'd1;
        if (head.halt) begin
          halted <= 1'b1;
        end
      end
      if (!wr_ok) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mon_commit_serializer.sv
// tb/tb_mon_commit_serializer.sv - self-checking bench for mon_commit_serializer
module tb_mon_commit_serializer;
  import mon_pkg::*;

  localparam int CH    = 2;
  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [CH-1:0]      in_valid;
  mon_pkt_t [CH-1:0]  in_pkt;
  logic               out_valid;
  mon_pkt_t           out_pkt;
  logic               halted;
  logic               overflow_err;
  logic               order_err;
  logic [4:0]         count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mon_commit_serializer #(.CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_pkt       (in_pkt),
    .out_valid    (out_valid),
    .out_pkt      (out_pkt),
    .halted       (halted),
    .overflow_err (overflow_err),
    .order_err    (order_err),
    .count        (count)
  );

  function automatic mon_pkt_t mk_pkt(input logic [63:0] ord, input logic h);
    mon_pkt_t p;
    p           = '0;
    p.order     = ord;
    p.inst      = $urandom;
    p.halt      = h;
    p.rs1_addr  = 5'($urandom);
    p.rs2_addr  = 5'($urandom);
    p.rs1_rdata = $urandom;
    p.rs2_rdata = $urandom;
    p.rd_addr   = 5'($urandom);
    p.rd_wdata  = $urandom;
    p.pc_rdata  = $urandom;
    p.pc_wdata  = $urandom;
    p.mem_addr  = $urandom;
    p.mem_rmask = 4'($urandom);
    p.mem_wmask = 4'($urandom);
    p.mem_rdata = $urandom;
    p.mem_wdata = $urandom;
    return p;
  endfunction

  task automatic drive(input logic [CH-1:0] v, input mon_pkt_t p0, input mon_pkt_t p1);
    in_valid  = v;
    in_pkt[0] = p0;
    in_pkt[1] = p1;
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    in_valid = '0;
    in_pkt   = '0;
    rst      = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    apply_reset();
    idle(10);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (out_pkt !== mon_pkt_t'('0)) begin bad++; $display("FAIL reset_out_pkt got=%h exp=0", out_pkt); end
    total++; if ({halted, overflow_err, order_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {halted, overflow_err, order_err}); end
  endtask

  task automatic test_in_order();
    mon_pkt_t a0, a1, a2;
    apply_reset();
    a0 = mk_pkt(64'd0, 1'b0);
    a1 = mk_pkt(64'd1, 1'b0);
    a2 = mk_pkt(64'd2, 1'b0);
    drive(2'b11, a0, a1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inorder_no_bypass got=%0b exp=0", out_valid); end
    total++; if (count !== 5'd2) begin bad++; $display("FAIL inorder_count0 got=%0d exp=2", count); end
    drive(2'b01, a2, mk_pkt(64'd99, 1'b0));
    total++; if (out_valid !== 1'b1 || out_pkt !== a0) begin bad++; $display("FAIL inorder_c1 got=%0b/%0d exp=1/0", out_valid, out_pkt.order); end
    total++; if (count !== 5'd2) begin bad++; $display("FAIL inorder_count1 got=%0d exp=2", count); end
    idle(1);
    total++; if (out_valid !== 1'b1 || out_pkt !== a1) begin bad++; $display("FAIL inorder_c2 got=%0b/%0d exp=1/1", out_valid, out_pkt.order); end
    idle(1);
    total++; if (out_valid !== 1'b1 || out_pkt !== a2) begin bad++; $display("FAIL inorder_c3 got=%0b/%0d exp=1/2", out_valid, out_pkt.order); end
    total++; if (order_err !== 1'b0) begin bad++; $display("FAIL inorder_order_err got=%0b exp=0", order_err); end
    idle(1);
    total++; if (out_valid !== 1'b0 || count !== 5'd0 || out_pkt !== a2) begin bad++; $display("FAIL inorder_drain got=%0b/%0d exp=0/0", out_valid, count); end
  endtask

  task automatic test_gap_then_halt();
    mon_pkt_t h5, p6;
    apply_reset();
    drive(2'b11, mk_pkt(64'd0, 1'b0), mk_pkt(64'd1, 1'b0));
    drive(2'b11, mk_pkt(64'd3, 1'b0), mk_pkt(64'd4, 1'b0));
    idle(1);
    total++; if (out_pkt.order !== 64'd1 || order_err !== 1'b0) begin bad++; $display("FAIL gap_before got=%0d/%0b exp=1/0", out_pkt.order, order_err); end
    idle(1);
    total++; if (out_pkt.order !== 64'd3 || order_err !== 1'b1) begin bad++; $display("FAIL gap_flag got=%0d/%0b exp=3/1", out_pkt.order, order_err); end
    idle(1);
    total++; if (out_pkt.order !== 64'd4 || dut.exp_order !== 64'd5) begin bad++; $display("FAIL gap_resync got=%0d/%0d exp=4/5", out_pkt.order, dut.exp_order); end
    h5 = mk_pkt(64'd5, 1'b1);
    p6 = mk_pkt(64'd6, 1'b0);
    drive(2'b11, h5, p6);
    idle(1);
    total++; if (out_valid !== 1'b1 || out_pkt !== h5 || halted !== 1'b1) begin bad++; $display("FAIL halt_emit got=%0b/%0d/%0b exp=1/5/1", out_valid, out_pkt.order, halted); end
    idle(4);
    total++; if (out_valid !== 1'b0 || out_pkt !== h5) begin bad++; $display("FAIL halt_frozen got=%0b/%0d exp=0/5", out_valid, out_pkt.order); end
    total++; if (count !== 5'd1 || halted !== 1'b1) begin bad++; $display("FAIL halt_count got=%0d/%0b exp=1/1", count, halted); end
  endtask

  task automatic test_overflow();
    logic [63:0] o;
    apply_reset();
    drive(2'b01, mk_pkt(64'd0, 1'b1), mk_pkt(64'd0, 1'b0));
    idle(1);
    total++; if (halted !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL ovf_halt got=%0b/%0d exp=1/0", halted, count); end
    o = 64'd1;
    for (int i = 0; i < 7; i++) begin
      drive(2'b11, mk_pkt(o, 1'b0), mk_pkt(o + 64'd1, 1'b0));
      o += 64'd2;
    end
    drive(2'b10, mk_pkt(64'd0, 1'b0), mk_pkt(o, 1'b0));
    total++; if (count !== 5'd15 || overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_fill got=%0d/%0b exp=15/0", count, overflow_err); end
    drive(2'b11, mk_pkt(o + 64'd1, 1'b0), mk_pkt(o + 64'd2, 1'b0));
    total++; if (count !== 5'd15 || overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_no_partial got=%0d/%0b exp=15/1", count, overflow_err); end
    drive(2'b01, mk_pkt(o + 64'd1, 1'b0), mk_pkt(64'd0, 1'b0));
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_full got=%0d exp=16", count); end
    drive(2'b01, mk_pkt(o + 64'd2, 1'b0), mk_pkt(64'd0, 1'b0));
    total++; if (count !== 5'd16 || overflow_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL ovf_one_more got=%0d/%0b exp=16/1", count, overflow_err); end
  endtask

  task automatic test_async_reset();
    mon_pkt_t z;
    apply_reset();
    drive(2'b01, mk_pkt(64'd0, 1'b1), mk_pkt(64'd0, 1'b0));
    idle(1);
    for (int i = 0; i < 3; i++) drive(2'b11, mk_pkt(64'(2 * i + 1), 1'b0), mk_pkt(64'(2 * i + 2), 1'b0));
    drive(2'b01, mk_pkt(64'd7, 1'b0), mk_pkt(64'd0, 1'b0));
    total++; if (count !== 5'd7 || halted !== 1'b1) begin bad++; $display("FAIL arst_setup got=%0d/%0b exp=7/1", count, halted); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (count !== 5'd0 || out_valid !== 1'b0 || out_pkt !== mon_pkt_t'('0)) begin bad++; $display("FAIL arst_outputs got=%0d/%0b exp=0/0", count, out_valid); end
    total++; if ({halted, overflow_err, order_err} !== 3'b000) begin bad++; $display("FAIL arst_flags got=%b exp=000", {halted, overflow_err, order_err}); end
    #2;
    rst = 1'b0;
    idle(1);
    z = mk_pkt(64'd0, 1'b0);
    drive(2'b01, z, mk_pkt(64'd0, 1'b0));
    idle(1);
    total++; if (out_valid !== 1'b1 || out_pkt !== z || order_err !== 1'b0) begin bad++; $display("FAIL arst_restart got=%0b/%0d/%0b exp=1/0/0", out_valid, out_pkt.order, order_err); end
  endtask

  // Reference: a queue of accepted packets; each cycle the pre-cycle head
  // (if any) is emitted and new packets are admitted only if they all fit
  // in the room left before that pop.
  task automatic test_random();
    mon_pkt_t    q[$];
    mon_pkt_t    p[CH];
    mon_pkt_t    m_pkt;
    logic [CH-1:0] v;
    logic        m_ov, m_ovf, m_oerr;
    logic [63:0] m_exp, next_ord;
    int          size_before, n;
    apply_reset();
    m_pkt = '0; m_ov = 0; m_ovf = 0; m_oerr = 0; m_exp = 0; next_ord = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 200) v = ($urandom_range(0, 9) < 6) ? 2'b11 : CH'($urandom_range(0, 3));
      else           v = CH'($urandom_range(0, 3));
      n = 0;
      for (int c = 0; c < CH; c++) begin
        p[c] = mk_pkt(64'd0, 1'b0);
        if (v[c]) begin
          if ($urandom_range(0, 15) == 0) next_ord += 64'd1;
          p[c].order = next_ord;
          next_ord  += 64'd1;
          n++;
        end
      end
      size_before = q.size();
      if (size_before != 0) begin
        m_ov  = 1'b1;
        m_pkt = q.pop_front();
        if (m_pkt.order != m_exp) m_oerr = 1'b1;
        m_exp = m_pkt.order + 64'd1;
      end else begin
        m_ov = 1'b0;
      end
      if (n > DEPTH - size_before) m_ovf = 1'b1;
      else for (int c = 0; c < CH; c++) if (v[c]) q.push_back(p[c]);
      drive(v, p[0], p[1]);
      total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rand_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, m_ov); end
      total++; if (out_pkt !== m_pkt) begin bad++; $display("FAIL rand_out_pkt cyc=%0d got=%0d exp=%0d", cyc, out_pkt.order, m_pkt.order); end
      total++; if (count !== 5'(q.size())) begin bad++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count, q.size()); end
      total++; if ({overflow_err, order_err, halted} !== {m_ovf, m_oerr, 1'b0}) begin bad++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", cyc, {overflow_err, order_err, halted}, {m_ovf, m_oerr, 1'b0}); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_pkt   = '0;
    test_reset();
    test_in_order();
    test_gap_then_halt();
    test_overflow();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
